// File: rtl/ldpc_encode_scheduler.sv
// ldpc_encode_scheduler
//
// Shares one QC-LDPC encoder among four requesters. Each request is a
// spatially-coupled job of L encoder passes (one per coupled position).
// Requesters are served round-robin. For every pass the scheduler pulses
// enc_start, waits for the encoder's done level, pulses enc_restart to put
// the encoder back to idle, then waits for done to fall before the next
// pass. A watchdog aborts a pass that waits longer than TIMEOUT cycles.
//
// Handshake: req[i] is a level held by requester i until it sees its
// one-cycle job_done[i] pulse; req/req_len are only looked at while idle.
// gnt[i] is high for the whole job and drops in the cycle job_done[i]
// pulses. enc_start/enc_restart are single-cycle pulses; enc_done is a
// level that stays high until the encoder has seen enc_restart.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req, req_len     per-requester request level and job length L
//   gnt, job_done    one-hot grant level and end-of-job pulse
//   sel, pos         granted requester index and current coupled position
//   busy             high whenever the FSM is not idle
//   enc_start        start pulse to the encoder
//   enc_restart      return-to-idle pulse to the encoder
//   enc_done         encoder done level
//   err_timeout      sticky watchdog flag, cleared by err_clr
//
// Every output comes straight from a flop; control pulses therefore appear
// in the cycle after the FSM state that requests them.

module ldpc_encode_scheduler #(
  parameter int POS_W   = 4,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*POS_W-1:0] req_len,
  output logic [3:0]         gnt,
  output logic [3:0]         job_done,
  output logic [1:0]         sel,
  output logic [POS_W-1:0]   pos,
  output logic               busy,
  output logic               enc_start,
  output logic               enc_restart,
  input  logic               enc_done,
  output logic               err_timeout,
  input  logic               err_clr
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LAUNCH   = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_RECOVER  = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_COMPLETE = 3'd5;
  localparam logic [2:0] S_ABORT    = 3'd6;

  localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [3:0]       job_done_q, job_done_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] len_q, len_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             busy_q, busy_d;
  logic             enc_start_q, enc_start_d;
  logic             enc_restart_q, enc_restart_d;
  logic             err_q, err_d;

  // Round-robin pick: scan last+1, last+2, ... (mod 4) for the first request.
  logic             arb_found;
  logic [1:0]       arb_idx;
  logic [1:0]       arb_cand;
  logic [POS_W-1:0] arb_len;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_q;
    arb_cand  = last_q;
    for (int k = 1; k <= 4; k++) begin
      arb_cand = last_q + 2'(k);
      if (!arb_found && req[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
    arb_len = req_len[arb_idx*POS_W +: POS_W];
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    job_done_d    = 4'b0000;
    sel_d         = sel_q;
    last_d        = last_q;
    pos_d         = pos_q;
    len_d         = len_q;
    timer_d       = timer_q;
    enc_start_d   = 1'b0;
    enc_restart_d = 1'b0;
    // A timeout later in this block overrides the clear (set wins).
    err_d         = err_clr ? 1'b0 : err_q;

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          sel_d  = arb_idx;
          last_d = arb_idx;
          len_d  = arb_len;
          if (arb_len == '0) begin
            // Zero-length job: acknowledge without touching the encoder.
            job_done_d = 4'b0001 << arb_idx;
          end else begin
            gnt_d   = 4'b0001 << arb_idx;
            pos_d   = '0;
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        enc_start_d = 1'b1;
        timer_d     = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // Done is checked first so a pass finishing on its last allowed
        // cycle is not counted as a timeout.
        if (enc_done) begin
          state_d = S_RECOVER;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = S_ABORT;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      S_RECOVER: begin
        enc_restart_d = 1'b1;
        state_d       = S_DRAIN;
      end
      S_DRAIN: begin
        // The encoder's done level must fall before the next start, or the
        // next WAIT would see the previous pass's done.
        if (!enc_done) begin
          if (pos_q == len_q - POS_W'(1)) begin
            state_d = S_COMPLETE;
          end else begin
            pos_d   = pos_q + POS_W'(1);
            state_d = S_LAUNCH;
          end
        end
      end
      S_COMPLETE: begin
        job_done_d = 4'b0001 << sel_q;
        gnt_d      = 4'b0000;
        pos_d      = '0;
        state_d    = S_IDLE;
      end
      S_ABORT: begin
        enc_restart_d = 1'b1;
        job_done_d    = 4'b0001 << sel_q;
        gnt_d         = 4'b0000;
        pos_d         = '0;
        state_d       = S_IDLE;
      end
      default: begin
        gnt_d   = 4'b0000;
        pos_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      gnt_q         <= 4'b0000;
      job_done_q    <= 4'b0000;
      sel_q         <= 2'd0;
      last_q        <= 2'd3;
      pos_q         <= '0;
      len_q         <= '0;
      timer_q       <= '0;
      busy_q        <= 1'b0;
      enc_start_q   <= 1'b0;
      enc_restart_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      job_done_q    <= job_done_d;
      sel_q         <= sel_d;
      last_q        <= last_d;
      pos_q         <= pos_d;
      len_q         <= len_d;
      timer_q       <= timer_d;
      busy_q        <= busy_d;
      enc_start_q   <= enc_start_d;
      enc_restart_q <= enc_restart_d;
      err_q         <= err_d;
    end
  end

  assign gnt         = gnt_q;
  assign job_done    = job_done_q;
  assign sel         = sel_q;
  assign pos         = pos_q;
  assign busy        = busy_q;
  assign enc_start   = enc_start_q;
  assign enc_restart = enc_restart_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ldpc_encode_scheduler.sv
// Testbench for ldpc_encode_scheduler: a behavioural encoder model plus a
// table of single-arbitration vectors and hand-written multi-cycle
// sequences (full job, round-robin, zero-length, timeout, slow drain,
// mid-job reset).

module tb_ldpc_encode_scheduler;

  localparam int POS_W   = 4;
  localparam int TIMEOUT = 256;
  localparam int TO_W    = 9;

  logic               clk;
  logic               rst_n;
  logic [3:0]         req;
  logic [4*POS_W-1:0] req_len;
  logic [3:0]         gnt;
  logic [3:0]         job_done;
  logic [1:0]         sel;
  logic [POS_W-1:0]   pos;
  logic               busy;
  logic               enc_start;
  logic               enc_restart;
  logic               enc_done;
  logic               err_timeout;
  logic               err_clr;

  ldpc_encode_scheduler #(
    .POS_W  (POS_W),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_len    (req_len),
    .gnt        (gnt),
    .job_done   (job_done),
    .sel        (sel),
    .pos        (pos),
    .busy       (busy),
    .enc_start  (enc_start),
    .enc_restart(enc_restart),
    .enc_done   (enc_done),
    .err_timeout(err_timeout),
    .err_clr    (err_clr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- encoder model ----------------
  // done rises enc_lat cycles after the start pulse (never, if enc_never),
  // and falls hold_cycles cycles after enc_restart (at once if 0).
  int enc_lat     = 5;
  bit enc_never   = 1'b0;
  int hold_cycles = 0;
  int run_cnt;
  bit running;
  int hold_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_done <= 1'b0;
      running  <= 1'b0;
      run_cnt  <= 0;
      hold_cnt <= 0;
    end else begin
      if (enc_restart) begin
        running <= 1'b0;
        if (hold_cycles == 0) enc_done <= 1'b0;
        else hold_cnt <= hold_cycles;
      end else if (hold_cnt > 0) begin
        hold_cnt <= hold_cnt - 1;
        if (hold_cnt == 1) enc_done <= 1'b0;
      end
      if (enc_start) begin
        running <= 1'b1;
        run_cnt <= 1;
      end else if (running) begin
        if (!enc_never && run_cnt >= enc_lat) begin
          enc_done <= 1'b1;
          running  <= 1'b0;
        end else begin
          run_cnt <= run_cnt + 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [POS_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n       = 1'b0;
    req         = 4'b0000;
    req_len     = '0;
    err_clr     = 1'b0;
    enc_never   = 1'b0;
    hold_cycles = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_len(input logic [POS_W-1:0] l);
    req_len = {4{l}};
  endtask

  task automatic wait_jd(input int idx, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (job_done[idx]) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_start(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (enc_start) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]       req;
    logic [POS_W-1:0] len;
    logic [1:0]       sel;
    logic [3:0]       gnt;
    logic [3:0]       jd;
    logic             busy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n_start, n_rst, n_jd, gap, ovl, errs, first_start, cyc, w, s;
    bit early, any;
    logic [1:0] rr_exp[5];

    // From reset the pointer is 3, so the scan order is 0,1,2,3.
    vecs[0] = '{4'b0001, 4'd2, 2'd0, 4'b0001, 4'b0000, 1'b1};
    vecs[1] = '{4'b0100, 4'd1, 2'd2, 4'b0100, 4'b0000, 1'b1};
    vecs[2] = '{4'b1010, 4'd1, 2'd1, 4'b0010, 4'b0000, 1'b1};
    vecs[3] = '{4'b1000, 4'd3, 2'd3, 4'b1000, 4'b0000, 1'b1};
    vecs[4] = '{4'b0100, 4'd0, 2'd2, 4'b0000, 4'b0100, 1'b0};
    vecs[5] = '{4'b1111, 4'd1, 2'd0, 4'b0001, 4'b0000, 1'b1};
    vecs[6] = '{4'b1100, 4'd0, 2'd2, 4'b0000, 4'b0100, 1'b0};

    rst_n   = 1'b0;
    req     = 4'b0000;
    req_len = '0;
    err_clr = 1'b0;
    @(negedge clk);
    check("rst_outputs", 32'({gnt, job_done, sel, pos, busy, enc_start, enc_restart, err_timeout}), 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      enc_lat = 5;
      set_len(vecs[i].len);
      req = vecs[i].req;
      @(negedge clk);
      check($sformatf("v%0d_sel", i),  32'(sel),      32'(vecs[i].sel));
      check($sformatf("v%0d_gnt", i),  32'(gnt),      32'(vecs[i].gnt));
      check($sformatf("v%0d_jd", i),   32'(job_done), 32'(vecs[i].jd));
      check($sformatf("v%0d_busy", i), 32'(busy),     32'(vecs[i].busy));
      req = 4'b0000;
      if (vecs[i].gnt != 4'b0000) wait_jd(int'(vecs[i].sel), 200, $sformatf("v%0d_done", i));
    end

    // ---- A: requester 0, L=3, encoder latency 100 ----
    do_reset();
    enc_lat = 100;
    set_len(4'd3);
    req = 4'b0001;
    @(negedge clk);
    check("a_gnt", 32'(gnt), 32'h1);
    check("a_no_start_in_launch", 32'(enc_start), 32'd0);
    exp_q = '{4'd0, 4'd1, 4'd2};
    n_start = 0; n_rst = 0; n_jd = 0; gap = 0; ovl = 0; errs = 0; first_start = -1;
    for (cyc = 1; cyc < 500 && n_jd == 0; cyc++) begin
      @(negedge clk);
      if (enc_start) begin
        n_start++;
        if (first_start < 0) first_start = cyc;
        if (exp_q.size() > 0) check("a_pos_at_start", 32'(pos), 32'(exp_q.pop_front()));
      end
      if (enc_restart) n_rst++;
      if (enc_start && enc_restart) ovl++;
      if (err_timeout) errs++;
      if (job_done != 4'b0000) begin
        n_jd++;
        check("a_jd_mask", 32'(job_done), 32'h1);
        check("a_gnt_drop", 32'(gnt), 32'h0);
      end else if (gnt != 4'b0001) begin
        gap++;
      end
    end
    req = 4'b0000;
    check("a_first_start_lag", 32'(first_start), 32'd1);
    check("a_starts", 32'(n_start), 32'd3);
    check("a_restarts", 32'(n_rst), 32'd3);
    check("a_job_done", 32'(n_jd), 32'd1);
    check("a_gnt_gap", 32'(gap), 32'd0);
    check("a_overlap", 32'(ovl), 32'd0);
    check("a_err", 32'(errs), 32'd0);
    @(negedge clk);
    check("a_idle", 32'({busy, job_done}), 32'd0);

    // ---- B: all four requesting, L=1, round-robin 0,1,2,3,0 ----
    do_reset();
    enc_lat = 3;
    set_len(4'd1);
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      w = 0;
      while (gnt == 4'b0000 && w < 50) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("b%0d_sel", g), 32'(sel), 32'(rr_exp[g]));
      check($sformatf("b%0d_gnt", g), 32'(gnt), 32'(4'b0001 << rr_exp[g]));
      if (g > 0) check($sformatf("b%0d_regrant_gap", g), 32'(w), 32'd1);
      wait_jd(int'(rr_exp[g]), 100, $sformatf("b%0d_done", g));
    end
    req = 4'b0000;

    // ---- C: requester 2 with L=0 ----
    do_reset();
    req_len = {4'd1, 4'd0, 4'd1, 4'd1};
    req = 4'b0100;
    @(negedge clk);
    check("c_jd", 32'(job_done), 32'h4);
    check("c_gnt", 32'(gnt), 32'h0);
    req = 4'b0000;
    any = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (enc_start || busy || gnt != 4'b0000 || job_done != 4'b0000) any = 1'b1;
    end
    check("c_quiet", 32'(any), 32'd0);

    // ---- D: timeout, abort, err_clr, clear/set collision ----
    do_reset();
    enc_never = 1'b1;
    set_len(4'd2);
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    wait_start(10, "d_start");
    w = 0;
    while (!err_timeout && w < TIMEOUT + 20) begin
      @(negedge clk);
      w++;
    end
    check("d_timeout_delay", 32'(w), 32'(TIMEOUT));
    @(negedge clk);
    check("d_abort_restart", 32'(enc_restart), 32'd1);
    check("d_abort_jd", 32'(job_done), 32'h1);
    check("d_abort_gnt", 32'(gnt), 32'h0);
    any = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (enc_start || busy) any = 1'b1;
    end
    check("d_positions_dropped", 32'(any), 32'd0);
    check("d_err_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("d_err_cleared", 32'(err_timeout), 32'd0);
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    wait_start(10, "d2_start");
    repeat (TIMEOUT - 1) @(negedge clk);
    check("d2_err_before", 32'(err_timeout), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("d2_set_wins", 32'(err_timeout), 32'd1);
    wait_jd(0, 10, "d2_done");
    enc_never = 1'b0;

    // ---- E: enc_done held 5 cycles after enc_restart ----
    do_reset();
    enc_lat = 4;
    hold_cycles = 5;
    set_len(4'd2);
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    w = 0;
    while (!enc_restart && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("e_restart_seen", 32'(enc_restart), 32'd1);
    early = 1'b0;
    w = 0;
    while (enc_done && w < 20) begin
      @(negedge clk);
      w++;
      if (enc_start) early = 1'b1;
      if (enc_done && !busy) early = 1'b1;
    end
    check("e_no_start_while_done", 32'(early), 32'd0);
    s = 0;
    while (!enc_start && s < 20) begin
      @(negedge clk);
      s++;
    end
    check("e_start_after_fall", 32'(s), 32'd2);
    check("e_pos", 32'(pos), 32'd1);
    wait_jd(0, 100, "e_done");
    hold_cycles = 0;

    // ---- F: asynchronous reset in WAIT with pos=1 ----
    do_reset();
    enc_lat = 50;
    set_len(4'd3);
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    w = 0;
    while (!(enc_start && pos == 4'd1) && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (5) @(negedge clk);
    check("f_pre_pos", 32'(pos), 32'd1);
    check("f_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("f_async_clear", 32'({gnt, job_done, sel, pos, busy, enc_start, enc_restart, err_timeout}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_len(4'd1);
    req = 4'b1001;
    @(negedge clk);
    check("f_prio_sel", 32'(sel), 32'd0);
    check("f_prio_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    wait_jd(0, 100, "f_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
